lfsr_stream: RTL and testbench

//  Parametrised Fibonacci LFSR pseudo-random source, width 3..32, advancing STEP bit-shifts per

---
 rtl/lfsr_stream.sv | 141 ++++++++++++++
 tb/tb_lfsr_stream.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lfsr_stream : Fibonacci LFSR word source (STEP shifts/word) on a valid/ready
// stream, with seed load, period-wrap pulse and all-zero lock-up recovery.
// Revision: 1.0
// ---------------------------------------------------------------------------
module lfsr_stream #(
  parameter int              DATA = 8,
  parameter int              STEP = 1,
  parameter logic [DATA-1:0] SEED = {{(DATA-1){1'b0}}, 1'b1}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            seed_load,
  input  logic [DATA-1:0] seed_in,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [DATA-1:0] out_data,
  output logic            wrap,
  output logic            lockup
);

  function automatic logic [31:0] bit_at(input int k);
    bit_at = 32'd1 << (k - 1);
  endfunction

  function automatic logic [31:0] tap_mask(input int w);
    case (w)
      3:       tap_mask = bit_at(3)  | bit_at(2);
      4:       tap_mask = bit_at(4)  | bit_at(3);
      5:       tap_mask = bit_at(5)  | bit_at(3);
      6:       tap_mask = bit_at(6)  | bit_at(5);
      7:       tap_mask = bit_at(7)  | bit_at(6);
      8:       tap_mask = bit_at(8)  | bit_at(6)  | bit_at(5)  | bit_at(4);
      9:       tap_mask = bit_at(9)  | bit_at(5);
      10:      tap_mask = bit_at(10) | bit_at(7);
      11:      tap_mask = bit_at(11) | bit_at(9);
      12:      tap_mask = bit_at(12) | bit_at(6)  | bit_at(4)  | bit_at(1);
      13:      tap_mask = bit_at(13) | bit_at(4)  | bit_at(3)  | bit_at(1);
      14:      tap_mask = bit_at(14) | bit_at(5)  | bit_at(3)  | bit_at(1);
      15:      tap_mask = bit_at(15) | bit_at(14);
      16:      tap_mask = bit_at(16) | bit_at(15) | bit_at(13) | bit_at(4);
      17:      tap_mask = bit_at(17) | bit_at(14);
      18:      tap_mask = bit_at(18) | bit_at(11);
      19:      tap_mask = bit_at(19) | bit_at(6)  | bit_at(2)  | bit_at(1);
      20:      tap_mask = bit_at(20) | bit_at(17);
      21:      tap_mask = bit_at(21) | bit_at(19);
      22:      tap_mask = bit_at(22) | bit_at(21);
      23:      tap_mask = bit_at(23) | bit_at(18);
      24:      tap_mask = bit_at(24) | bit_at(23) | bit_at(22) | bit_at(17);
      25:      tap_mask = bit_at(25) | bit_at(22);
      26:      tap_mask = bit_at(26) | bit_at(6)  | bit_at(2)  | bit_at(1);
      27:      tap_mask = bit_at(27) | bit_at(5)  | bit_at(2)  | bit_at(1);
      28:      tap_mask = bit_at(28) | bit_at(25);
      29:      tap_mask = bit_at(29) | bit_at(27);
      30:      tap_mask = bit_at(30) | bit_at(6)  | bit_at(4)  | bit_at(1);
      31:      tap_mask = bit_at(31) | bit_at(28);
      32:      tap_mask = bit_at(32) | bit_at(22) | bit_at(2)  | bit_at(1);
      default: tap_mask = 32'd0;
    endcase
  endfunction

  localparam logic [31:0]     TAPS_32  = tap_mask(DATA);
  localparam logic [DATA-1:0] TAPS     = TAPS_32[DATA-1:0];
  localparam logic [DATA-1:0] ONE      = {{(DATA-1){1'b0}}, 1'b1};
  localparam logic [DATA-1:0] SEED_FIX = (SEED == '0) ? ONE : SEED;
  localparam logic [DATA:0]   PERIOD   = {1'b0, {DATA{1'b1}}};
  localparam logic [DATA:0]   STEP_W   = (DATA + 1)'(STEP);

  if (DATA < 3 || DATA > 32) begin : g_bad_data
    $error("lfsr_stream: DATA=%0d outside legal range 3..32", DATA);
    $fatal(1, "lfsr_stream: illegal DATA parameter");
  end

  if (STEP < 1 || STEP > DATA) begin : g_bad_step
    $fatal(1, "lfsr_stream: STEP=%0d outside legal range 1..DATA", STEP);
  end

  logic [DATA-1:0] state;
  logic [DATA-1:0] cnt;
  logic [DATA-1:0] stepped;
  logic [DATA-1:0] seed_fix;
  logic [DATA:0]   cnt_sum;
  logic [DATA-1:0] cnt_next;
  logic            cnt_hit;
  logic            adv;

  // All STEP single-bit shifts are unrolled into one combinational cone.
  always_comb begin
    stepped = state;
    for (int i = 0; i < STEP; i++) begin
      stepped = {stepped[DATA-2:0], ^(stepped & TAPS)};
    end
  end

  always_comb begin
    cnt_sum  = {1'b0, cnt} + STEP_W;
    cnt_hit  = (cnt_sum >= PERIOD);
    cnt_next = cnt_sum[DATA-1:0];
    if (cnt_hit) begin
      cnt_next = cnt_sum[DATA-1:0] - PERIOD[DATA-1:0];
    end
  end

  assign seed_fix = (seed_in == '0) ? ONE : seed_in;
  assign adv      = en & ~seed_load & (~out_valid | out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEED_FIX;
      out_data  <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      lockup    <= 1'b0;
      cnt       <= '0;
    end else begin
      wrap   <= 1'b0;
      lockup <= 1'b0;
      if (seed_load) begin
        state     <= seed_fix;
        out_valid <= 1'b0;
        cnt       <= '0;
      end else if (state == '0) begin
        // Recovery only touches the state; the stream and counter are left alone.
        state  <= ONE;
        lockup <= 1'b1;
      end else if (adv) begin
        state     <= stepped;
        out_data  <= stepped;
        out_valid <= 1'b1;
        cnt       <= cnt_next;
        wrap      <= cnt_hit;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lfsr_stream : scoreboard bench for lfsr_stream, DATA=4 with STEP=1 and 2.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_lfsr_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       seed_load;
  logic [3:0] seed_in;
  logic       out_ready;

  logic       a_valid, a_wrap, a_lockup;
  logic [3:0] a_data;
  logic       b_valid, b_wrap, b_lockup;
  logic [3:0] b_data;

  int tests = 0;
  int fails = 0;
  string phase = "init";

  // Entry layout: {check_wrap, wrap, data}
  logic [5:0] qa[$];
  logic [5:0] qb[$];
  logic [3:0] t1[16];
  logic [3:0] t2[15];

  always #5 clk = ~clk;

  lfsr_stream #(.DATA(4), .STEP(1)) dut_a (
    .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .out_ready(out_ready), .out_valid(a_valid), .out_data(a_data),
    .wrap(a_wrap), .lockup(a_lockup)
  );

  lfsr_stream #(.DATA(4), .STEP(2)) dut_b (
    .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .out_ready(out_ready), .out_valid(b_valid), .out_data(b_data),
    .wrap(b_wrap), .lockup(b_lockup)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // T1 table wraps on index 14; T2 table wraps on indices 7 and 14.
  task automatic push_t1(input int n);
    for (int i = 0; i < n; i++) qa.push_back({1'b1, (i == 14), t1[i % 16]});
  endtask

  task automatic push_t2();
    for (int i = 0; i < 15; i++) qb.push_back({1'b1, (i == 7 || i == 14), t2[i]});
  endtask

  task automatic sample_pop();
    logic [5:0] ent;
    if (a_valid && out_ready && qa.size() > 0) begin
      ent = qa.pop_front();
      check("a_data", {28'd0, a_data}, {28'd0, ent[3:0]});
      if (ent[5]) check("a_wrap", {31'd0, a_wrap}, {31'd0, ent[4]});
    end
    if (b_valid && out_ready && qb.size() > 0) begin
      ent = qb.pop_front();
      check("b_data", {28'd0, b_data}, {28'd0, ent[3:0]});
      if (ent[5]) check("b_wrap", {31'd0, b_wrap}, {31'd0, ent[4]});
    end
  endtask

  task automatic drain_queues(input int budget);
    for (int c = 0; c < budget && (qa.size() > 0 || qb.size() > 0); c++) begin
      sample_pop();
      tick();
    end
    check("a_queue_left", qa.size(), 0);
    check("b_queue_left", qb.size(), 0);
    qa.delete();
    qb.delete();
  endtask

  initial begin
    t1 = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
           4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2};
    t2 = '{4'h4, 4'h3, 4'hD, 4'h5, 4'h7, 4'hE, 4'h8, 4'h2,
           4'h9, 4'h6, 4'hA, 4'hB, 4'hF, 4'hC, 4'h1};

    reset = 1'b1; en = 1'b0; seed_load = 1'b0; seed_in = 4'd0; out_ready = 1'b1;
    tick();
    tick();
    phase = "reset";
    check("a_valid", {31'd0, a_valid}, 0);
    check("a_data", {28'd0, a_data}, 0);
    check("a_wrap", {31'd0, a_wrap}, 0);
    check("a_lockup", {31'd0, a_lockup}, 0);
    check("b_valid", {31'd0, b_valid}, 0);

    // T1/T2: free-running stream from reset seed
    phase = "T1T2";
    reset = 1'b0;
    en = 1'b1;
    push_t1(16);
    push_t2();
    sample_pop();
    tick();
    check("latency_a_valid", {31'd0, a_valid}, 1);
    drain_queues(40);

    // T4: seed_load of zero restarts the sequence from 1 and clears the counter
    phase = "T4";
    seed_load = 1'b1;
    seed_in = 4'd0;
    push_t1(15);
    push_t2();
    tick();
    check("a_valid_drop", {31'd0, a_valid}, 0);
    check("b_valid_drop", {31'd0, b_valid}, 0);
    seed_load = 1'b0;

    // T3: stall the first word for 5 cycles
    phase = "T3";
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("a_stall_valid", {31'd0, a_valid}, 1);
      check("a_stall_data", {28'd0, a_data}, 4'h2);
      check("a_stall_wrap", {31'd0, a_wrap}, 0);
      check("b_stall_data", {28'd0, b_data}, 4'h4);
      tick();
    end
    out_ready = 1'b1;
    drain_queues(40);

    // Transfer with en low empties the stream but keeps the last word
    phase = "drain";
    en = 1'b0;
    tick();
    check("a_valid", {31'd0, a_valid}, 0);
    check("a_data_hold", {28'd0, a_data}, 4'h2);
    check("b_data_hold", {28'd0, b_data}, 4'h4);

    // T5: all-zero state deposit
    phase = "T5";
    dut_a.state = 4'd0;
    tick();
    check("a_lockup", {31'd0, a_lockup}, 1);
    check("b_lockup", {31'd0, b_lockup}, 0);
    check("a_valid", {31'd0, a_valid}, 0);
    check("a_state", {28'd0, dut_a.state}, 1);
    tick();
    check("a_lockup_clear", {31'd0, a_lockup}, 0);
    en = 1'b1;
    qa.push_back({2'b00, 4'h2});
    qa.push_back({2'b00, 4'h4});
    drain_queues(10);

    // T6: reset with a word pending under backpressure
    phase = "T6";
    out_ready = 1'b0;
    tick();
    check("a_pending", {31'd0, a_valid}, 1);
    reset = 1'b1;
    tick();
    check("a_valid", {31'd0, a_valid}, 0);
    check("a_data", {28'd0, a_data}, 0);
    check("b_valid", {31'd0, b_valid}, 0);
    check("b_data", {28'd0, b_data}, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    push_t1(16);
    push_t2();
    drain_queues(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
